alu_bus_arbiter: RTL and testbench
==================================

# alu_bus_arbiter

Two-master arbiter sharing the ALU_Top slave bus (s_sel/s_wr/s_addr/s_din/s_dout/s_interrupt). It grants the bus round-robin, locks ownership for a whole ALU job (start write through interrupt clear) so instruction, operand and result traffic from two hosts never interleaves, and routes s_interrupt only to the master that started the job. It sits between the host masters and ALU_Top.

## Interface
- START_ADDR, 16'h0000, operation-start register address
- CLR_ADDR, 16'h0002, interrupt-clear register address
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- m0_req / m1_req  input  1  bus request, held high for the whole tenure
- m0_gnt / m1_gnt  output  1  registered grant
- m0_sel, m0_wr / m1_sel, m1_wr  input  1  slave select and write strobe, honoured only while granted
- m0_addr / m1_addr  input  16  register address
- m0_din / m1_din  input  32  write data
- m0_dout / m1_dout  output  32  read data: s_dout when granted, else 0
- m0_interrupt / m1_interrupt  output  1  job-done interrupt, job owner only
- s_sel, s_wr  output  1  to ALU_Top slave
- s_addr  output  16  to slave
- s_din  output  32  to slave
- s_dout  input  32  from slave
- s_interrupt  input  1  from slave

## Operation
- States: IDLE, OWN0, OWN1. last_grant bit for round-robin; job_active bit; job_owner bit.
- IDLE: m0_req only → OWN0; m1_req only → OWN1; both → the master that is not last_grant.
- OWNx: stay while mx_req=1 or (job_active and job_owner=x). Otherwise leave: other req high → OWN(other) directly, no IDLE cycle; else IDLE. last_grant ← x on leaving.
- Forwarding (combinational from state): s_* = owner's sel/wr/addr/din; in IDLE s_sel=s_wr=0, s_addr=0, s_din=0. Non-owner sel is dropped, never reaches slave.
- Job tracking: owner write (sel&wr) to START_ADDR with din[0]=1 → job_active=1, job_owner=x at that edge. Owner write to CLR_ADDR → job_active=0 at that edge (write still forwarded).
- A master dropping req during job_active keeps the grant (gnt stays 1) until the clear write; other master waits.
- mx_interrupt = s_interrupt & job_active & (job_owner==x). s_interrupt with no job active is dropped.

## Timing
- Reset: state IDLE, m0_gnt=m1_gnt=0, job_active=0, job_owner=0, last_grant=1 (m0 wins first tie); all outputs 0.
- Request-to-grant latency: 1 clock (req sampled at edge N, gnt high after edge N).
- Bus forwarding: zero added latency; slave sees owner's strobe in the same cycle.
- Handover: owner req low sampled at edge N → old gnt low and new gnt high after edge N.
- Simultaneous start write and other master's req: grant locks to writer; other waits.
- Simultaneous CLR write and req drop by owner: job clears and grant releases at the same edge.
- Reset mid-tenure or mid-job: immediate return to reset values; slave not informed.

## Structure
- Package alu_bus_pkg: slave address constants (START 0x0000, INT 0x0001, CLR 0x0002, INSTR 0x0003, RESULT 0x0004, STATUS 0x0005, OPERAND 0x0010–0x001F), arbiter state enum.
- Sub-module rr_arb2: two-request round-robin grant logic with last_grant register; top holds job tracking and bus mux.

## Test plan
- Reset then m0_req=1 only → m0_gnt=1 one cycle later; m0 write addr 0x0003 din 0x3C04 → appears on s_* same cycle.
- Both req rise same cycle after reset → m0 granted; m0 drops req → m1_gnt=1 at next edge, m0_gnt=0; next tie → m1 loses? No: last_grant=1, so m0 wins.
- m1 drives sel=1 without grant, addr 0x0010 din 5 → s_sel stays 0, m1_dout=0.
- m0 writes 0x0000 din 1, drops req; m1_req high → m0_gnt stays 1; s_interrupt=1 → m0_interrupt=1, m1_interrupt=0; m0 writes 0x0002 → m1_gnt=1 next edge.
- s_interrupt=1 with job_active=0 → both interrupts 0.
- reset_n low while OWN1 and job active → gnts, interrupts, s_sel 0 immediately; after release m0 wins tie.

Source files
------------

// File: rtl/alu_bus_pkg.sv
// Purpose: shared ALU slave register map and arbiter state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_bus_pkg;

    // ALU_Top slave register map
    localparam logic [15:0] START_ADDR   = 16'h0000;
    localparam logic [15:0] INT_ADDR     = 16'h0001;
    localparam logic [15:0] CLR_ADDR     = 16'h0002;
    localparam logic [15:0] INSTR_ADDR   = 16'h0003;
    localparam logic [15:0] RESULT_ADDR  = 16'h0004;
    localparam logic [15:0] STATUS_ADDR  = 16'h0005;
    localparam logic [15:0] OPERAND_BASE = 16'h0010;
    localparam logic [15:0] OPERAND_LAST = 16'h001F;

    // Bus ownership: nobody, master 0, or master 1
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-request round-robin owner FSM with per-master hold (lock) inputs.
// Latency: request sampled at an edge becomes ownership after that same edge.
// Backpressure: a held owner (req or lock high) blocks the other master indefinitely.
module rr_arb2
    import alu_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output arb_state_t state
);

    logic       last_grant;
    logic       last_grant_nxt;
    arb_state_t state_nxt;

    // Ownership and round-robin history registers; last_grant=1 makes m0 win the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Next owner: hand over directly to a waiting master without an IDLE bubble
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            ST_IDLE: begin
                if (req[0] && req[1]) begin
                    state_nxt = last_grant ? ST_OWN0 : ST_OWN1;
                end else if (req[0]) begin
                    state_nxt = ST_OWN0;
                end else if (req[1]) begin
                    state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!(req[0] || lock[0])) begin
                    last_grant_nxt = 1'b0;
                    state_nxt      = req[1] ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!(req[1] || lock[1])) begin
                    last_grant_nxt = 1'b1;
                    state_nxt      = req[0] ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/alu_bus_arbiter.sv
// Purpose: share the ALU_Top slave bus between two masters, locking ownership for a whole job.
// Latency: grant 1 clock after request; bus forwarding and interrupt routing are combinational.
// Backpressure: non-owner waits on gnt; its strobes are dropped, and its read data is forced to 0.
module alu_bus_arbiter
    import alu_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m1_req,
    output logic        m0_gnt,
    output logic        m1_gnt,
    input  logic        m0_sel,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_din,
    output logic [31:0] m0_dout,
    output logic        m0_interrupt,
    input  logic        m1_sel,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_din,
    output logic [31:0] m1_dout,
    output logic        m1_interrupt,
    output logic        s_sel,
    output logic        s_wr,
    output logic [15:0] s_addr,
    output logic [31:0] s_din,
    input  logic [31:0] s_dout,
    input  logic        s_interrupt
);

    arb_state_t state;
    logic       own0;
    logic       own1;
    logic       job_active;
    logic       job_owner;
    logic       start_wr;
    logic       clr_wr;
    logic [1:0] lock;

    assign own0 = (state == ST_OWN0);
    assign own1 = (state == ST_OWN1);

    // Only the owner's strobes reach the slave, so job decode can look at s_* directly
    assign start_wr = s_sel && s_wr && (s_addr == START_ADDR) && s_din[0];
    assign clr_wr   = s_sel && s_wr && (s_addr == CLR_ADDR);

    // Hold ownership through the job; a start write locks at its own edge and a
    // clear write releases at its own edge, so neither costs an extra cycle
    assign lock[0] = (own0 && start_wr) || (job_active && !job_owner && !clr_wr);
    assign lock[1] = (own1 && start_wr) || (job_active &&  job_owner && !clr_wr);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({m1_req, m0_req}),
        .lock    (lock),
        .state   (state)
    );

    // Job tracking: set by the owner's start write, cleared by its clear write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job_active <= 1'b0;
            job_owner  <= 1'b0;
        end else if (start_wr) begin
            job_active <= 1'b1;
            job_owner  <= own1;
        end else if (clr_wr) begin
            job_active <= 1'b0;
        end
    end

    // Slave-side mux: owner's request fields, all zero while idle
    always_comb begin
        s_sel  = 1'b0;
        s_wr   = 1'b0;
        s_addr = '0;
        s_din  = '0;
        if (own0) begin
            s_sel  = m0_sel;
            s_wr   = m0_wr;
            s_addr = m0_addr;
            s_din  = m0_din;
        end else if (own1) begin
            s_sel  = m1_sel;
            s_wr   = m1_wr;
            s_addr = m1_addr;
            s_din  = m1_din;
        end
    end

    // Grants come straight from the ownership register
    assign m0_gnt = own0;
    assign m1_gnt = own1;

    assign m0_dout = own0 ? s_dout : '0;
    assign m1_dout = own1 ? s_dout : '0;

    // Interrupt goes only to the master that started the running job
    assign m0_interrupt = s_interrupt && job_active && !job_owner;
    assign m1_interrupt = s_interrupt && job_active &&  job_owner;

endmodule

// File: tb/tb_alu_bus_arbiter.sv
module tb_alu_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m1_req;
    logic        m0_gnt, m1_gnt;
    logic        m0_sel, m0_wr, m1_sel, m1_wr;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_din, m1_din;
    logic [31:0] m0_dout, m1_dout;
    logic        m0_interrupt, m1_interrupt;
    logic        s_sel, s_wr;
    logic [15:0] s_addr;
    logic [31:0] s_din;
    logic [31:0] s_dout;
    logic        s_interrupt;

    int checks;
    int failures;

    alu_bus_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_req       (m0_req),
        .m1_req       (m1_req),
        .m0_gnt       (m0_gnt),
        .m1_gnt       (m1_gnt),
        .m0_sel       (m0_sel),
        .m0_wr        (m0_wr),
        .m0_addr      (m0_addr),
        .m0_din       (m0_din),
        .m0_dout      (m0_dout),
        .m0_interrupt (m0_interrupt),
        .m1_sel       (m1_sel),
        .m1_wr        (m1_wr),
        .m1_addr      (m1_addr),
        .m1_din       (m1_din),
        .m1_dout      (m1_dout),
        .m1_interrupt (m1_interrupt),
        .s_sel        (s_sel),
        .s_wr         (s_wr),
        .s_addr       (s_addr),
        .s_din        (s_din),
        .s_dout       (s_dout),
        .s_interrupt  (s_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0_drive(input logic sel, input logic wr, input logic [15:0] addr, input logic [31:0] din);
        m0_sel = sel; m0_wr = wr; m0_addr = addr; m0_din = din;
    endtask

    task automatic m1_drive(input logic sel, input logic wr, input logic [15:0] addr, input logic [31:0] din);
        m1_sel = sel; m1_wr = wr; m1_addr = addr; m1_din = din;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_drive(1'b0, 1'b0, 16'h0, 32'h0);
        m1_drive(1'b0, 1'b0, 16'h0, 32'h0);
        s_dout = 32'h1234_5678;
        s_interrupt = 1'b1;

        // Reset state: no grants, idle bus, read data and stray interrupt blocked
        #12;
        check("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        check("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        check("rst_s_sel", {31'b0, s_sel}, 32'd0);
        check("rst_m0_dout", m0_dout, 32'd0);
        check("rst_ints", {30'b0, m1_interrupt, m0_interrupt}, 32'd0);
        s_interrupt = 1'b0;
        reset_n = 1'b1;
        tick();

        // Tie after reset: m0 wins, grant appears one edge later
        m0_req = 1'b1; m1_req = 1'b1;
        #1;
        check("pre_gnt_m0", {31'b0, m0_gnt}, 32'd0);
        tick();
        check("tie1_gnts", {30'b0, m1_gnt, m0_gnt}, 32'b01);

        // Owner traffic forwarded same cycle; non-owner strobe dropped
        m0_drive(1'b1, 1'b1, 16'h0003, 32'h0000_3C04);
        m1_drive(1'b1, 1'b1, 16'h0010, 32'h0000_0005);
        #1;
        check("fwd_s_sel", {30'b0, s_sel, s_wr}, 32'b11);
        check("fwd_s_addr", {16'b0, s_addr}, 32'h0003);
        check("fwd_s_din", s_din, 32'h0000_3C04);
        check("fwd_m0_dout", m0_dout, 32'h1234_5678);
        check("fwd_m1_dout", m1_dout, 32'd0);
        m0_drive(1'b0, 1'b0, 16'h0, 32'h0);

        // Handover: m0 drops req, m1 owns after next edge with no idle gap
        m0_req = 1'b0;
        tick();
        check("handover_gnts", {30'b0, m1_gnt, m0_gnt}, 32'b10);
        #1;
        check("m1_fwd_addr", {16'b0, s_addr}, 32'h0010);
        check("m1_fwd_din", s_din, 32'h0000_0005);
        check("m1_fwd_dout", m1_dout, 32'h1234_5678);

        // m1 releases to idle; its strobe no longer reaches the slave
        m1_req = 1'b0;
        tick();
        check("idle_gnts", {30'b0, m1_gnt, m0_gnt}, 32'b00);
        check("idle_s_sel", {31'b0, s_sel}, 32'd0);
        check("idle_s_din", s_din, 32'd0);
        check("idle_m1_dout", m1_dout, 32'd0);
        m1_drive(1'b0, 1'b0, 16'h0, 32'h0);

        // Next tie: last grant was m1, so m0 wins
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        check("tie2_gnts", {30'b0, m1_gnt, m0_gnt}, 32'b01);

        // Interrupt without a running job is dropped
        s_interrupt = 1'b1;
        #1;
        check("noj_ints", {30'b0, m1_interrupt, m0_interrupt}, 32'd0);
        s_interrupt = 1'b0;

        // m0 starts a job, then drops req: grant held while m1 waits
        m0_drive(1'b1, 1'b1, 16'h0000, 32'h0000_0001);
        tick();
        m0_drive(1'b0, 1'b0, 16'h0, 32'h0);
        m0_req = 1'b0;
        tick();
        check("job_hold_gnts", {30'b0, m1_gnt, m0_gnt}, 32'b01);
        s_interrupt = 1'b1;
        #1;
        check("job_ints_m0", {30'b0, m1_interrupt, m0_interrupt}, 32'b01);
        tick();
        check("job_hold2_gnts", {30'b0, m1_gnt, m0_gnt}, 32'b01);

        // Clear write is forwarded and releases grant to m1 at that edge
        m0_drive(1'b1, 1'b1, 16'h0002, 32'h0);
        #1;
        check("clr_fwd_addr", {16'b0, s_addr}, 32'h0002);
        tick();
        m0_drive(1'b0, 1'b0, 16'h0, 32'h0);
        check("clr_gnts", {30'b0, m1_gnt, m0_gnt}, 32'b10);
        check("clr_ints", {30'b0, m1_interrupt, m0_interrupt}, 32'd0);

        // m1 starts its own job; interrupt routed only to m1
        m1_drive(1'b1, 1'b1, 16'h0000, 32'h0000_0001);
        tick();
        check("job1_ints", {30'b0, m1_interrupt, m0_interrupt}, 32'b10);

        // Asynchronous reset mid-job: everything drops without a clock edge
        m0_req = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_gnts", {30'b0, m1_gnt, m0_gnt}, 32'd0);
        check("arst_ints", {30'b0, m1_interrupt, m0_interrupt}, 32'd0);
        check("arst_s_sel", {31'b0, s_sel}, 32'd0);
        check("arst_m1_dout", m1_dout, 32'd0);
        m1_drive(1'b0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // After reset, tie goes to m0 and the old job is gone
        tick();
        check("post_rst_gnts", {30'b0, m1_gnt, m0_gnt}, 32'b01);
        check("post_rst_ints", {30'b0, m1_interrupt, m0_interrupt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
